// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU issue stage: data/register widths, ALU opcodes,
// the packed command word carried through the command FIFO, and the sequencer
// FSM state encoding.
package alu_pkg;

  localparam int DATA_W    = 8;
  localparam int REG_IDX_W = 3;
  localparam int OP_W      = 3;
  localparam int NREGS     = 8;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_SLL = 3'd2;
  localparam logic [OP_W-1:0] OP_LSR = 3'd3;
  localparam logic [OP_W-1:0] OP_AND = 3'd4;
  localparam logic [OP_W-1:0] OP_OR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XOR = 3'd6;
  localparam logic [OP_W-1:0] OP_EQL = 3'd7;

  // Command word as stored in the FIFO: {op, rd, rs1, rs2, imm_en, imm} = 21 bits.
  typedef struct packed {
    logic [OP_W-1:0]      op;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic                 imm_en;
    logic [DATA_W-1:0]    imm;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo
// Synchronous FIFO holding pending ALU commands. Pointers carry one extra wrap
// bit so full and empty are distinguished without a separate counter; both
// flags are derived from registers only.
// Ports:
//   clk, rst    clock, asynchronous active-high reset (empties the FIFO)
//   push, din   write request and data (ignored while full, even if popping)
//   pop, dout   read request and head-of-queue data (ignored while empty)
//   full, empty status flags
module alu_cmd_fifo #(
  parameter int WIDTH = alu_pkg::CMD_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when the head is leaving in the same cycle,
  // which keeps full (and therefore cmd_ready) a pure function of the pointers.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[PTR_W-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Issue stage for the external 8-bit combinational ALU. Commands are buffered
// in a small FIFO, operands are read from an 8x8 register file (r0 reads 0),
// a/b/op are registered towards the ALU, and the ALU result is captured one
// cycle later, written back to rd and offered on a valid/ready result port.
// Only one command is in flight at a time.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready = FIFO not full)
//   cmd_op/rd/rs1/rs2/imm_en/imm  command fields
//   alu_a/alu_b/alu_op            registered operands/opcode to the ALU
//   alu_o                         ALU result
//   res_valid/res_ready           result handshake
//   res_data/res_rd               captured result and its destination register
//   busy                          FSM not idle or commands still queued
module alu_cmd_sequencer #(
  parameter int DATA_W     = alu_pkg::DATA_W,
  parameter int NREGS      = alu_pkg::NREGS,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [alu_pkg::OP_W-1:0]      cmd_op,
  input  logic [alu_pkg::REG_IDX_W-1:0] cmd_rd,
  input  logic [alu_pkg::REG_IDX_W-1:0] cmd_rs1,
  input  logic [alu_pkg::REG_IDX_W-1:0] cmd_rs2,
  input  logic                          cmd_imm_en,
  input  logic [DATA_W-1:0]             cmd_imm,
  output logic [DATA_W-1:0]             alu_a,
  output logic [DATA_W-1:0]             alu_b,
  output logic [alu_pkg::OP_W-1:0]      alu_op,
  input  logic [DATA_W-1:0]             alu_o,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATA_W-1:0]             res_data,
  output logic [alu_pkg::REG_IDX_W-1:0] res_rd,
  output logic                          busy
);

  import alu_pkg::*;

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic [DATA_W-1:0]    regs [NREGS];
  logic [REG_IDX_W-1:0] pend_rd;

  cmd_t                 cmd_in;
  cmd_t                 head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 issue;
  logic [DATA_W-1:0]    op_a;
  logic [DATA_W-1:0]    op_b;

  assign cmd_in = {cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm};

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .din   (cmd_in),
    .pop   (issue),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A new command issues from IDLE, or straight out of RESP when the result is
  // being taken, so back-to-back commands cost two cycles each.
  assign issue = !fifo_empty &&
                 ((state == ST_IDLE) || ((state == ST_RESP) && res_ready));

  // Register reads; r0 is hard-wired to zero regardless of storage contents.
  assign op_a = (head.rs1 == '0) ? '0 : regs[head.rs1];
  assign op_b = head.imm_en ? head.imm :
                ((head.rs2 == '0) ? '0 : regs[head.rs2]);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (issue) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (res_ready) state_next = issue ? ST_EXEC : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Write-back happens on the EXEC->RESP edge, always at least one cycle before
  // the next operand read, so read-after-write needs no forwarding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      pend_rd  <= '0;
      res_data <= '0;
      res_rd   <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state <= state_next;
      if (issue) begin
        alu_a   <= op_a;
        alu_b   <= op_b;
        alu_op  <= head.op;
        pend_rd <= head.rd;
      end
      if (state == ST_EXEC) begin
        res_data <= alu_o;
        res_rd   <= pend_rd;
        if (pend_rd != '0) regs[pend_rd] <= alu_o;
      end
    end
  end

  assign res_valid = (state == ST_RESP);
  assign cmd_ready = !fifo_full;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
// Self-checking bench for alu_cmd_sequencer. Provides a behavioural ALU on
// alu_o, drives directed and random commands, and compares every accepted
// result against an architectural model that executes commands sequentially
// in push order on its own copy of the register file.
module tb_alu_cmd_sequencer;

  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [2:0] cmd_rd = '0;
  logic [2:0] cmd_rs1 = '0;
  logic [2:0] cmd_rs2 = '0;
  logic       cmd_imm_en = 1'b0;
  logic [7:0] cmd_imm = '0;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_o;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic [2:0] res_rd;
  logic       busy;

  int total = 0;
  int bad = 0;
  int ready_mode = 1;

  typedef struct {
    logic [7:0] data;
    logic [2:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   model_regs[8];

  alu_cmd_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_imm_en (cmd_imm_en),
    .cmd_imm    (cmd_imm),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_o      (alu_o),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_rd     (res_rd),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Plain-arithmetic ALU, 8-bit wrap
  function automatic logic [7:0] aluRef(input logic [2:0] op, input int a, input int b);
    int r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = (b > 7) ? 0 : (a << b);
      3'd3:    r = (b > 7) ? 0 : (a >> b);
      3'd4:    r = a & b;
      3'd5:    r = a | b;
      3'd6:    r = a ^ b;
      default: r = (a == b) ? 1 : 0;
    endcase
    return r[7:0];
  endfunction

  always_comb alu_o = aluRef(alu_op, int'(alu_a), int'(alu_b));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sequential architectural execution of one accepted command
  task automatic modelPush(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                           input logic [2:0] rs2, input logic imm_en, input logic [7:0] imm);
    int a;
    int b;
    exp_t e;
    a = (rs1 == 0) ? 0 : model_regs[rs1];
    b = imm_en ? int'(imm) : ((rs2 == 0) ? 0 : model_regs[rs2]);
    e.data = aluRef(op, a, b);
    e.rd   = rd;
    if (rd != 0) model_regs[rd] = int'(e.data);
    exp_q.push_back(e);
  endtask

  task automatic modelReset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) model_regs[i] = 0;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                               input logic [2:0] rs2, input logic imm_en, input logic [7:0] imm);
    int w = 0;
    @(negedge clk);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_imm_en = imm_en; cmd_imm = imm;
    cmd_valid = 1'b1;
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    checkOutput("cmd_accept", 32'(cmd_ready), 32'd1);
    if (cmd_ready) begin
      modelPush(op, rd, rs1, rs2, imm_en, imm);
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_busy", 32'(busy), 32'd0);
    checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Result consumer: choose res_ready for the coming edge, then score a handshake
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      case (ready_mode)
        0:       res_ready = 1'b0;
        1:       res_ready = 1'b1;
        default: res_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("res_unexpected", 32'(res_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("res_data", 32'(res_data), 32'(e.data));
          checkOutput("res_rd", 32'(res_rd), 32'(e.rd));
        end
      end
    end
  end

  initial begin
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
    checkOutput("rst_alu_b", 32'(alu_b), 32'd0);
    checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
    checkOutput("rst_res_data", 32'(res_data), 32'd0);
    checkOutput("rst_res_rd", 32'(res_rd), 32'd0);
    rst = 1'b0;

    $display("[TB] latency");
    ready_mode = 1;
    applyStimulus(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05);
    @(posedge clk); #1;
    checkOutput("lat_alu_op", 32'(alu_op), 32'd0);
    checkOutput("lat_alu_b", 32'(alu_b), 32'h05);
    checkOutput("lat_valid_early", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("lat_res_valid", 32'(res_valid), 32'd1);
    checkOutput("lat_res_data", 32'(res_data), 32'h05);
    checkOutput("lat_res_rd", 32'(res_rd), 32'd1);
    waitIdle();

    $display("[TB] reset during EXEC");
    applyStimulus(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05);
    @(posedge clk); #1;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("rx_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rx_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rx_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(OP_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 8'h00);
    waitIdle();

    $display("[TB] RAW chain");
    applyStimulus(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'hF0);
    applyStimulus(OP_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 8'h20);
    applyStimulus(OP_SUB, 3'd3, 3'd2, 3'd1, 1'b0, 8'h00);
    waitIdle();

    $display("[TB] backpressure");
    ready_mode = 0;
    applyStimulus(OP_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 8'h11);
    applyStimulus(OP_ADD, 3'd5, 3'd4, 3'd0, 1'b1, 8'h22);
    applyStimulus(OP_XOR, 3'd6, 3'd5, 3'd4, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("bp_res_valid", 32'(res_valid), 32'd1);
    checkOutput("bp_busy", 32'(busy), 32'd1);
    fork
      applyStimulus(OP_OR, 3'd7, 3'd6, 3'd0, 1'b1, 8'h80);
      begin
        repeat (4) @(negedge clk);
        ready_mode = 1;
      end
    join
    waitIdle();

    $display("[TB] r0 write");
    applyStimulus(OP_XOR, 3'd0, 3'd0, 3'd0, 1'b1, 8'hFF);
    applyStimulus(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h00);
    waitIdle();

    $display("[TB] shift and compare");
    applyStimulus(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h81);
    applyStimulus(OP_LSR, 3'd2, 3'd1, 3'd0, 1'b1, 8'h01);
    applyStimulus(OP_EQL, 3'd3, 3'd1, 3'd0, 1'b1, 8'h81);
    applyStimulus(OP_SLL, 3'd3, 3'd3, 3'd3, 1'b0, 8'h00);
    waitIdle();

    $display("[TB] random");
    ready_mode = 2;
    for (int i = 0; i < 150; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 9))
                                                : 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    waitIdle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
